// File: rtl/bus_cycle_controller.sv
// 68000-style asynchronous bus-cycle engine: turns byte/word/long transfer
// requests into strobed bus cycles terminated by DTACK, BERR or a watchdog.
module bus_cycle_controller #(
    parameter int ADDR_WIDTH = 23,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH:0]   req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  berr_err,
    output logic                  addr_err,
    output logic [31:0]           rdata,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  AS,
    output logic                  UDS,
    output logic                  LDS,
    output logic                  RW,
    output logic [15:0]           D_out,
    output logic                  D_oe,
    input  logic [15:0]           D_in,
    input  logic                  DTACK,
    input  logic                  BERR
);
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic                  as_q, as_d;
    logic                  uds_q, uds_d;
    logic                  lds_q, lds_d;
    logic                  rw_q, rw_d;
    logic [15:0]           dout_q, dout_d;
    logic                  doe_q, doe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  berr_q, berr_d;
    logic                  aerr_q, aerr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  write_q, write_d;
    logic                  byte_q, byte_d;
    logic                  long_q, long_d;
    logic                  odd_q, odd_d;
    logic                  second_q, second_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [15:0]           hi_q, hi_d;

    logic                  new_byte;
    logic                  new_long;
    logic [WD_W-1:0]       wd_inc;
    logic                  timeout_hit;
    logic [31:0]           read_result;

    // Returns {UDS, LDS}, active low: even byte on the upper lane.
    function automatic logic [1:0] lane_strobes(input logic is_byte, input logic odd);
        if (!is_byte) begin
            return 2'b00;
        end
        return odd ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [15:0] bus_wdata(input logic is_byte, input logic is_long,
                                              input logic second, input logic [31:0] wd);
        if (is_byte) begin
            return {wd[7:0], wd[7:0]};
        end
        if (is_long && !second) begin
            return wd[31:16];
        end
        return wd[15:0];
    endfunction

    assign new_byte    = (req_size == 2'b00);
    assign new_long    = (req_size == 2'b10);
    assign wd_inc      = wd_q + WD_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (wd_inc == WD_LIMIT);

    always_comb begin
        read_result = {16'h0000, D_in};
        if (byte_q) begin
            read_result = {24'h000000, (odd_q ? D_in[7:0] : D_in[15:8])};
        end else if (long_q) begin
            read_result = {hi_q, D_in};
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        as_d     = as_q;
        uds_d    = uds_q;
        lds_d    = lds_q;
        rw_d     = rw_q;
        dout_d   = dout_q;
        doe_d    = doe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        berr_d   = 1'b0;
        aerr_d   = 1'b0;
        rdata_d  = rdata_q;
        wd_d     = wd_q;
        write_d  = write_q;
        byte_d   = byte_q;
        long_d   = long_q;
        odd_d    = odd_q;
        second_d = second_q;
        wdata_d  = wdata_q;
        hi_d     = hi_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    write_d  = req_write;
                    byte_d   = new_byte;
                    long_d   = new_long;
                    odd_d    = req_addr[0];
                    second_d = 1'b0;
                    wdata_d  = req_wdata;
                    busy_d   = 1'b1;
                    if (!new_byte && req_addr[0]) begin
                        // Misaligned word/long: report immediately, bus untouched.
                        state_d = S_RELEASE;
                        done_d  = 1'b1;
                        aerr_d  = 1'b1;
                    end else begin
                        state_d = S_ASSERT;
                        a_d     = req_addr[ADDR_WIDTH:1];
                        as_d    = 1'b0;
                        rw_d    = ~req_write;
                        if (req_write) begin
                            doe_d  = 1'b1;
                            dout_d = bus_wdata(new_byte, new_long, 1'b0, req_wdata);
                        end else begin
                            {uds_d, lds_d} = lane_strobes(new_byte, req_addr[0]);
                        end
                    end
                end
            end

            S_ASSERT: begin
                state_d = S_WAIT;
                wd_d    = '0;
                if (write_q) begin
                    {uds_d, lds_d} = lane_strobes(byte_q, odd_q);
                end
            end

            S_WAIT: begin
                if (BERR || DTACK || timeout_hit) begin
                    state_d = S_RELEASE;
                    as_d    = 1'b1;
                    uds_d   = 1'b1;
                    lds_d   = 1'b1;
                    doe_d   = 1'b0;
                    if (BERR || !DTACK) begin
                        done_d = 1'b1;
                        berr_d = 1'b1;
                    end else if (long_q && !second_q) begin
                        hi_d = D_in;
                    end else begin
                        done_d = 1'b1;
                        if (!write_q) begin
                            rdata_d = read_result;
                        end
                    end
                end else begin
                    wd_d = wd_inc;
                end
            end

            S_RELEASE: begin
                // No done pulse here means a clean first half of a long transfer.
                if (!done_q) begin
                    state_d  = S_ASSERT;
                    second_d = 1'b1;
                    a_d      = a_q + 1'b1;
                    as_d     = 1'b0;
                    if (write_q) begin
                        doe_d  = 1'b1;
                        dout_d = bus_wdata(byte_q, long_q, 1'b1, wdata_q);
                    end else begin
                        {uds_d, lds_d} = lane_strobes(byte_q, odd_q);
                    end
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    rw_d    = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            as_q     <= 1'b1;
            uds_q    <= 1'b1;
            lds_q    <= 1'b1;
            rw_q     <= 1'b1;
            dout_q   <= '0;
            doe_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            berr_q   <= 1'b0;
            aerr_q   <= 1'b0;
            rdata_q  <= '0;
            wd_q     <= '0;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            long_q   <= 1'b0;
            odd_q    <= 1'b0;
            second_q <= 1'b0;
            wdata_q  <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            as_q     <= as_d;
            uds_q    <= uds_d;
            lds_q    <= lds_d;
            rw_q     <= rw_d;
            dout_q   <= dout_d;
            doe_q    <= doe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            berr_q   <= berr_d;
            aerr_q   <= aerr_d;
            rdata_q  <= rdata_d;
            wd_q     <= wd_d;
            write_q  <= write_d;
            byte_q   <= byte_d;
            long_q   <= long_d;
            odd_q    <= odd_d;
            second_q <= second_d;
            wdata_q  <= wdata_d;
            hi_q     <= hi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign berr_err = berr_q;
    assign addr_err = aerr_q;
    assign rdata    = rdata_q;
    assign A        = a_q;
    assign AS       = as_q;
    assign UDS      = uds_q;
    assign LDS      = lds_q;
    assign RW       = rw_q;
    assign D_out    = dout_q;
    assign D_oe     = doe_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Scoreboard bench for bus_cycle_controller: a transfer-level model predicts
// each bus half and each completion; a bus responder and a monitor check them.
module tb_bus_cycle_controller;
    localparam int AW = 23;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          req = 1'b0;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic [AW:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          busy, done, berr_err, addr_err;
    logic [31:0]   rdata;
    logic [AW-1:0] A;
    logic          AS, UDS, LDS, RW;
    logic [15:0]   D_out;
    logic          D_oe;
    logic [15:0]   D_in = '0;
    logic          DTACK = 1'b0;
    logic          BERR = 1'b0;

    bus_cycle_controller #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .berr_err(berr_err), .addr_err(addr_err),
        .rdata(rdata), .A(A), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
        .D_out(D_out), .D_oe(D_oe), .D_in(D_in), .DTACK(DTACK), .BERR(BERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          done_cyc;
        bit          berr;
        bit          aerr;
        bit          chk_rd;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic [AW-1:0] a;
        bit            wr;
        bit            uds;
        bit            lds;
        logic [15:0]   dout;
        int            w;
        int            kind;   // 0 DTACK, 1 BERR, 2 both
        logic [15:0]   din;
    } half_t;

    exp_t  exp_q[$];
    half_t half_q[$];

    int checks = 0;
    int failures = 0;
    logic [31:0] last_rd = '0;
    bit rd_known = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req_v, cyc);
        end
    endtask

    // Transfer-level prediction, then drive the request and wait for completion.
    task automatic issue(input bit wr, input logic [1:0] sz, input logic [AW:0] addr,
                         input logic [31:0] wd, input int k0, input int w0, input logic [15:0] d0,
                         input int k1, input int w1, input logic [15:0] d1);
        int          esz, nh, lat, wc;
        bit          err, got;
        int          ks[2];
        int          ws[2];
        logic [15:0] ds[2];
        logic [AW:0] ba;
        logic [31:0] rnd;
        half_t       h;
        exp_t        e;
        ks[0] = k0; ks[1] = k1; ws[0] = w0; ws[1] = w1; ds[0] = d0; ds[1] = d1;
        @(negedge CLK);
        esz = (sz == 2'b11) ? 1 : int'(sz);
        e.berr = 1'b0; e.aerr = 1'b0; e.rd = last_rd; e.chk_rd = rd_known;
        if (esz != 0 && addr[0]) begin
            lat = 1;
            e.aerr = 1'b1;
        end else begin
            nh = (esz == 2) ? 2 : 1;
            lat = 0;
            err = 1'b0;
            for (int i = 0; i < nh && !err; i++) begin
                ba = addr + (AW + 1)'(2 * i);
                h.a = ba[AW:1];
                h.wr = wr;
                h.uds = (esz == 0 && addr[0]);
                h.lds = (esz == 0 && !addr[0]);
                if (esz == 0) h.dout = {wd[7:0], wd[7:0]};
                else if (esz == 2 && i == 0) h.dout = wd[31:16];
                else h.dout = wd[15:0];
                h.w = ws[i]; h.kind = ks[i]; h.din = ds[i];
                half_q.push_back(h);
                wc = (ws[i] + 1 < TO) ? ws[i] + 1 : TO;
                lat += 2 + wc;
                if (ks[i] != 0 || ws[i] >= TO) err = 1'b1;
            end
            e.berr = err;
            if (!wr) begin
                if (err) begin
                    e.chk_rd = 1'b0;
                    rd_known = 1'b0;
                end else begin
                    if (esz == 0) e.rd = {24'h0, (addr[0] ? d0[7:0] : d0[15:8])};
                    else if (esz == 1) e.rd = {16'h0, d0};
                    else e.rd = {d0, d1};
                    e.chk_rd = 1'b1;
                    last_rd = e.rd;
                    rd_known = 1'b1;
                end
            end
        end
        e.done_cyc = cyc + lat;
        exp_q.push_back(e);
        req = 1'b1; req_write = wr; req_size = sz; req_addr = addr; req_wdata = wd;
        @(posedge CLK);
        #1 req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge CLK);
            if (done) begin
                got = 1'b1;
            end else begin
                // Garbage requests while busy must be ignored.
                rnd = $urandom;
                req = rnd[0]; req_write = rnd[1]; req_size = rnd[3:2];
                rnd = $urandom;
                req_addr = rnd[AW:0];
                req_wdata = $urandom;
            end
        end
        req = 1'b0;
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Bus responder: checks each strobed half against the plan and terminates it.
    initial begin
        half_t cur;
        int    as_cnt;
        bit    have;
        as_cnt = 0;
        have = 1'b0;
        forever begin
            @(negedge CLK);
            DTACK = 1'b0;
            BERR = 1'b0;
            D_in = 16'($urandom);
            if (RESET) begin
                as_cnt = 0;
                have = 1'b0;
            end else if (AS == 1'b0) begin
                if (as_cnt == 0) begin
                    if (half_q.size() == 0) begin
                        check("unexpected_as", 32'(AS), 32'd1);
                        have = 1'b0;
                    end else begin
                        cur = half_q.pop_front();
                        have = 1'b1;
                    end
                end
                as_cnt++;
                if (have) begin
                    check("bus_A", 32'(A), 32'(cur.a));
                    check("bus_RW", 32'(RW), 32'(!cur.wr));
                    check("bus_D_oe", 32'(D_oe), 32'(cur.wr));
                    if (cur.wr) check("bus_D_out", 32'(D_out), 32'(cur.dout));
                    check("bus_UDS", 32'(UDS), 32'((cur.wr && as_cnt == 1) ? 1'b1 : cur.uds));
                    check("bus_LDS", 32'(LDS), 32'((cur.wr && as_cnt == 1) ? 1'b1 : cur.lds));
                    if (as_cnt >= 2 && (as_cnt - 1) > cur.w) begin
                        DTACK = (cur.kind != 1);
                        BERR = (cur.kind != 0);
                        D_in = cur.din;
                    end
                end
            end else begin
                as_cnt = 0;
                have = 1'b0;
                check("idle_strobes", 32'({UDS, LDS, D_oe}), 32'(3'b110));
            end
        end
    end

    // Completion monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                        check("berr_err", 32'(berr_err), 32'(e.berr));
                        check("addr_err", 32'(addr_err), 32'(e.aerr));
                        if (e.chk_rd) check("rdata", rdata, e.rd);
                        $display("txn done cyc=%0d berr=%0b aerr=%0b rdata=%h", cyc, berr_err, addr_err, rdata);
                    end
                end else begin
                    check("err_flags_idle", 32'({berr_err, addr_err}), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] r1, r2, r3;
        bit          wr;
        int          k0, k1, w0, w1;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_A", 32'(A), 32'd0);
        check("rst_strobes", 32'({AS, UDS, LDS, RW}), 32'hF);
        check("rst_D_out", 32'(D_out), 32'd0);
        check("rst_flags", 32'({D_oe, busy, done, berr_err, addr_err}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        RESET = 1'b0;

        issue(1'b0, 2'b01, 24'h000100, 32'h0, 0, 2, 16'hBEEF, 0, 0, 16'h0);
        issue(1'b1, 2'b00, 24'h000103, 32'h5A, 0, 0, 16'h0, 0, 0, 16'h0);
        issue(1'b0, 2'b10, 24'h000200, 32'h0, 0, 0, 16'h1234, 0, 0, 16'h5678);
        issue(1'b0, 2'b10, 24'h000200, 32'h0, 2, 0, 16'h1111, 0, 0, 16'h2222);
        issue(1'b1, 2'b01, 24'h000011, 32'hCAFE, 0, 0, 16'h0, 0, 0, 16'h0);
        issue(1'b0, 2'b01, 24'h000040, 32'h0, 0, 9, 16'h7777, 0, 0, 16'h0);
        issue(1'b0, 2'b01, 24'h000042, 32'h0, 0, 3, 16'hA5C3, 0, 0, 16'h0);
        issue(1'b1, 2'b10, 24'hFFFFFE, 32'hDEAD_BEEF, 0, 1, 16'h0, 0, 2, 16'h0);
        issue(1'b0, 2'b11, 24'h000300, 32'h0, 0, 0, 16'h4242, 0, 0, 16'h0);
        issue(1'b0, 2'b00, 24'h000300, 32'h0, 0, 0, 16'hABCD, 0, 0, 16'h0);

        for (int n = 0; n < 70; n++) begin
            r1 = $urandom; r2 = $urandom; r3 = $urandom;
            wr = r1[0];
            k0 = (r1[3:1] == 3'd0) ? 1 : ((r1[3:1] == 3'd1) ? 2 : 0);
            k1 = (r1[6:4] == 3'd0) ? 1 : ((r1[6:4] == 3'd1) ? 2 : 0);
            w0 = $urandom_range(0, 5);
            w1 = $urandom_range(0, 5);
            issue(wr, r1[9:8], r2[AW:0], r3, k0, w0, 16'($urandom), k1, w1, 16'($urandom));
        end

        // Reset during the WAIT phase of a long read.
        @(negedge CLK);
        begin
            half_t h;
            h.a = 23'h000180; h.wr = 1'b0; h.uds = 1'b0; h.lds = 1'b0;
            h.dout = '0; h.w = 20; h.kind = 0; h.din = 16'h0;
            half_q.push_back(h);
        end
        req = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 24'h000300;
        @(posedge CLK);
        #1 req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        half_q.delete();
        check("midrst_strobes", 32'({AS, UDS, LDS}), 32'h7);
        check("midrst_flags", 32'({D_oe, busy, done}), 32'd0);
        check("midrst_A", 32'(A), 32'd0);
        RESET = 1'b0;
        last_rd = '0;
        rd_known = 1'b1;
        repeat (3) @(negedge CLK);
        issue(1'b0, 2'b01, 24'h000500, 32'h0, 0, 1, 16'h600D, 0, 0, 16'h0);

        repeat (4) @(negedge CLK);
        check("halves_left", 32'(half_q.size()), 32'd0);
        check("txns_left", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
